// File: rtl/crp16_mem_pkg.sv
// Shared definitions for the CRP16 port-B memory arbiter: default widths,
// requester identifiers and the arbiter state encoding.
package crp16_mem_pkg;

  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_DATA_W         = 16;
  localparam int DEF_HOST_BURST_MAX = 4;

  // Width of the host burst counter (HOST_BURST_MAX is limited to 1..15)
  localparam int BURST_CNT_W = 4;

  // Requester identifiers, also used as the encoding of last_grant
  localparam logic ID_CPU  = 1'b0;
  localparam logic ID_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_HOST = 2'b10
  } arb_state_t;

  // Map a requester identifier onto the grant state that serves it
  function automatic arb_state_t grant_state(input logic id);
    arb_state_t st;
    if (id == ID_HOST) begin
      st = GNT_HOST;
    end else begin
      st = GNT_CPU;
    end
    return st;
  endfunction

endpackage

// File: rtl/crp16_rr_arbiter2.sv
// Two-input round-robin next-grant selector. The host override wins a tie
// when set; otherwise a tie goes to the requester that was not granted last.
module crp16_rr_arbiter2
  import crp16_mem_pkg::*;
(
  input  logic cpu_valid,
  input  logic host_valid,
  input  logic last_grant,
  input  logic host_override,
  output logic gnt_valid,
  output logic gnt_id
);

  // Pick the next grant from the valid requesters and the round-robin pointer
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ID_CPU;
    case ({cpu_valid, host_valid})
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = ID_CPU;
      end
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = ID_HOST;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        if (host_override) begin
          gnt_id = ID_HOST;
        end else if (last_grant == ID_HOST) begin
          gnt_id = ID_CPU;
        end else begin
          gnt_id = ID_HOST;
        end
      end
      default: begin
        gnt_valid = 1'b0;
        gnt_id    = ID_CPU;
      end
    endcase
  end

endmodule

// File: rtl/crp16_mem_arbiter.sv
// Shares memory port B between the CPU load/store stage and a host
// requester. One access per cycle, round-robin, with a bounded host burst
// lock. Grants last one cycle; the port-B signals are steered
// combinationally from the granted requester and read data is captured at
// the end of the grant cycle.
module crp16_mem_arbiter
  import crp16_mem_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int HOST_BURST_MAX = DEF_HOST_BURST_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_wren,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_wren,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(HOST_BURST_MAX);

  arb_state_t              state_r;
  arb_state_t              state_nxt_s;
  logic                    last_grant_r;
  logic                    last_grant_nxt_s;
  logic [BURST_CNT_W-1:0]  burst_cnt_r;
  logic [BURST_CNT_W-1:0]  burst_cnt_nxt_s;
  logic [DATA_W-1:0]       cpu_rdata_r;
  logic [DATA_W-1:0]       host_rdata_r;

  logic cpu_gnt_s;
  logic host_gnt_s;
  logic lock_ovr_s;
  logic cpu_valid_s;
  logic host_valid_s;
  logic arb_valid_s;
  logic arb_id_s;

  // Decode the effective grant of this cycle; a requester that dropped its
  // request before being served is treated as withdrawn and gets no access
  always_comb begin
    cpu_gnt_s  = 1'b0;
    host_gnt_s = 1'b0;
    case (state_r)
      GNT_CPU: begin
        cpu_gnt_s = cpu_req;
      end
      GNT_HOST: begin
        host_gnt_s = host_req;
      end
      IDLE: begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
      end
      default: begin
        cpu_gnt_s  = 1'b0;
        host_gnt_s = 1'b0;
      end
    endcase
  end

  // The host may keep the port across consecutive accesses only while it
  // holds the lock and the burst budget is not exhausted. A requester being
  // acked now is otherwise not a candidate at this edge, which prevents a
  // double issue of the same held request.
  assign lock_ovr_s   = host_gnt_s & host_lock & (burst_cnt_r < BURST_MAX);
  assign cpu_valid_s  = cpu_req & ~cpu_gnt_s;
  assign host_valid_s = host_req & (~host_gnt_s | lock_ovr_s);

  crp16_rr_arbiter2 u_rr (
    .cpu_valid     (cpu_valid_s),
    .host_valid    (host_valid_s),
    .last_grant    (last_grant_r),
    .host_override (lock_ovr_s),
    .gnt_valid     (arb_valid_s),
    .gnt_id        (arb_id_s)
  );

  // Next state, round-robin pointer and burst count for the coming edge
  always_comb begin
    state_nxt_s      = IDLE;
    last_grant_nxt_s = last_grant_r;
    burst_cnt_nxt_s  = {BURST_CNT_W{1'b0}};
    if (arb_valid_s) begin
      state_nxt_s      = grant_state(arb_id_s);
      last_grant_nxt_s = arb_id_s;
      if ((arb_id_s == ID_HOST) && host_gnt_s && host_lock) begin
        if (burst_cnt_r < BURST_MAX) begin
          burst_cnt_nxt_s = burst_cnt_r + 4'd1;
        end else begin
          burst_cnt_nxt_s = BURST_MAX;
        end
      end else begin
        burst_cnt_nxt_s = {BURST_CNT_W{1'b0}};
      end
    end else begin
      state_nxt_s      = IDLE;
      last_grant_nxt_s = last_grant_r;
      burst_cnt_nxt_s  = {BURST_CNT_W{1'b0}};
    end
  end

  // Arbiter state register; reset leaves the host as last grant so the CPU
  // wins the first tie
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= ID_HOST;
      burst_cnt_r  <= {BURST_CNT_W{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      burst_cnt_r  <= burst_cnt_nxt_s;
    end
  end

  // Capture CPU load data at the end of its read grant; stores leave it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_rdata_r <= {DATA_W{1'b0}};
    end else if (cpu_gnt_s && !cpu_wren) begin
      cpu_rdata_r <= q_b;
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
    end
  end

  // Capture host read data at the end of its read grant; writes leave it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      host_rdata_r <= {DATA_W{1'b0}};
    end else if (host_gnt_s && !host_wren) begin
      host_rdata_r <= q_b;
    end else begin
      host_rdata_r <= host_rdata_r;
    end
  end

  // Steer port B from the granted requester; drive zeros when nobody is
  // served so the RAM sees no write outside a grant
  always_comb begin
    address_b = {ADDR_W{1'b0}};
    data_b    = {DATA_W{1'b0}};
    wren_b    = 1'b0;
    if (cpu_gnt_s) begin
      address_b = cpu_addr;
      data_b    = cpu_wdata;
      wren_b    = cpu_wren;
    end else if (host_gnt_s) begin
      address_b = host_addr;
      data_b    = host_wdata;
      wren_b    = host_wren;
    end else begin
      address_b = {ADDR_W{1'b0}};
      data_b    = {DATA_W{1'b0}};
      wren_b    = 1'b0;
    end
  end

  assign cpu_ack    = cpu_gnt_s;
  assign host_ack   = host_gnt_s;
  assign cpu_stall  = cpu_req & ~cpu_gnt_s;
  assign cpu_rdata  = cpu_rdata_r;
  assign host_rdata = host_rdata_r;

endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// Directed bench for crp16_mem_arbiter with a small behavioural RAM on port B.
module tb_crp16_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_wren;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        host_req;
  logic        host_lock;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_wren;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [15:0] address_b;
  logic [15:0] data_b;
  logic        wren_b;
  logic [15:0] q_b;

  int compares     = 0;
  int fails        = 0;
  int proto_checks = 0;
  int proto_fails  = 0;

  // RAM model: unwritten words read back a fixed pattern
  logic [15:0]  mem [0:255];
  logic [255:0] written = '0;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {8'hA0, a};
  endfunction

  always_comb begin
    if (written[address_b[7:0]]) q_b = mem[address_b[7:0]];
    else                         q_b = init_val(address_b[7:0]);
  end

  always @(posedge clock) begin
    if (wren_b) begin
      mem[address_b[7:0]]     <= data_b;
      written[address_b[7:0]] <= 1'b1;
    end
  end

  crp16_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .HOST_BURST_MAX(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wren(cpu_wren), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req), .host_lock(host_lock), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wren(host_wren), .host_ack(host_ack),
    .host_rdata(host_rdata),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Requester stability: inputs of an acked requester must match the
  // values it presented in the cycle before the ack
  logic        p_cpu_req, p_cpu_wren, p_host_req, p_host_wren;
  logic [15:0] p_cpu_addr, p_cpu_wdata, p_host_addr, p_host_wdata;

  always @(posedge clock) begin
    p_cpu_req    <= cpu_req;
    p_cpu_addr   <= cpu_addr;
    p_cpu_wdata  <= cpu_wdata;
    p_cpu_wren   <= cpu_wren;
    p_host_req   <= host_req;
    p_host_addr  <= host_addr;
    p_host_wdata <= host_wdata;
    p_host_wren  <= host_wren;
  end

  always @(negedge clock) begin
    if (cpu_ack && p_cpu_req) begin
      proto_checks++;
      assert ({cpu_addr, cpu_wdata, cpu_wren} === {p_cpu_addr, p_cpu_wdata, p_cpu_wren}) else begin
        proto_fails++;
        $error("FAIL cpu_protocol: inputs changed before ack (addr %0h was %0h)", cpu_addr, p_cpu_addr);
      end
    end
    if (host_ack && p_host_req) begin
      proto_checks++;
      assert ({host_addr, host_wdata, host_wren} === {p_host_addr, p_host_wdata, p_host_wren}) else begin
        proto_fails++;
        $error("FAIL host_protocol: inputs changed before ack (addr %0h was %0h)", host_addr, p_host_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  logic [15:0] word;

  initial begin
    cpu_req = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0; cpu_wren = 1'b0;
    host_req = 1'b0; host_lock = 1'b0; host_addr = 16'h0;
    host_wdata = 16'h0; host_wren = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_cpu_ack",    32'(cpu_ack),    32'd0);
    chk("rst_host_ack",   32'(host_ack),   32'd0);
    chk("rst_address_b",  32'(address_b),  32'd0);
    chk("rst_data_b",     32'(data_b),     32'd0);
    chk("rst_wren_b",     32'(wren_b),     32'd0);
    chk("rst_cpu_rdata",  32'(cpu_rdata),  32'd0);
    chk("rst_host_rdata", 32'(host_rdata), 32'd0);
    step(); step();
    reset = 1'b1;

    // CPU-only read of 0x0010
    step(); cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_wren = 1'b0; #1;
    chk("t1_c1_stall", 32'(cpu_stall), 32'd1);
    chk("t1_c1_ack",   32'(cpu_ack),   32'd0);
    step(); #1;
    chk("t1_c2_ack",   32'(cpu_ack),   32'd1);
    chk("t1_c2_addr",  32'(address_b), 32'h0010);
    chk("t1_c2_wren",  32'(wren_b),    32'd0);
    chk("t1_c2_stall", 32'(cpu_stall), 32'd0);
    step(); cpu_req = 1'b0; #1;
    chk("t1_c3_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("t1_c3_ack",   32'(cpu_ack),   32'd0);
    chk("t1_c3_addr",  32'(address_b), 32'd0);
    chk("t1_c3_stall", 32'(cpu_stall), 32'd0);

    // Simultaneous requests after reset: CPU store wins, host read follows
    #1 reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    cpu_req = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234; cpu_wren = 1'b1;
    host_req = 1'b1; host_addr = 16'h0020; host_wren = 1'b0;
    #1;
    chk("t2_c1_stall", 32'(cpu_stall), 32'd1);
    step(); #1;
    chk("t2_c2_cpu_ack",  32'(cpu_ack),  32'd1);
    chk("t2_c2_host_ack", 32'(host_ack), 32'd0);
    chk("t2_c2_wren",     32'(wren_b),   32'd1);
    chk("t2_c2_data",     32'(data_b),   32'h1234);
    chk("t2_c2_addr",     32'(address_b), 32'h0020);
    step(); cpu_req = 1'b0; #1;
    chk("t2_c3_host_ack", 32'(host_ack), 32'd1);
    chk("t2_c3_cpu_ack",  32'(cpu_ack),  32'd0);
    chk("t2_c3_wren",     32'(wren_b),   32'd0);
    step(); host_req = 1'b0; #1;
    chk("t2_c4_host_rdata", 32'(host_rdata), 32'h1234);
    chk("t2_c4_host_ack",   32'(host_ack),   32'd0);

    // Round-robin fairness: both hold requests for 6 accesses each
    step();
    cpu_req = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 16'h0; cpu_wren = 1'b0;
    host_req = 1'b1; host_addr = 16'h0031; host_wren = 1'b0;
    #1;
    chk("t3_start_idle", 32'({cpu_ack, host_ack}), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 11) cpu_req = 1'b0;
      #1;
      chk("t3_cpu_ack",  32'(cpu_ack),  32'((i % 2) == 0));
      chk("t3_host_ack", 32'(host_ack), 32'((i % 2) == 1));
      chk("t3_addr",     32'(address_b), ((i % 2) == 0) ? 32'h0030 : 32'h0031);
    end
    step(); host_req = 1'b0; #1;
    chk("t3_end_idle",   32'({cpu_ack, host_ack}), 32'd0);
    chk("t3_end_addr",   32'(address_b),  32'd0);
    chk("t3_cpu_rdata",  32'(cpu_rdata),  32'hA030);
    chk("t3_host_rdata", 32'(host_rdata), 32'hA031);

    // Host burst lock: 4 more locked grants, one CPU grant, host resumes
    step();
    host_req = 1'b1; host_lock = 1'b1; host_addr = 16'h0040; host_wren = 1'b0;
    #1;
    chk("t4_b1_host_ack", 32'(host_ack), 32'd0);
    step(); #1;
    chk("t4_b2_host_ack", 32'(host_ack), 32'd1);
    cpu_req = 1'b1; cpu_addr = 16'h0050; cpu_wren = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      if (j == 5) begin
        cpu_req = 1'b0;
        host_lock = 1'b0;
      end
      #1;
      chk("t4_cpu_ack",  32'(cpu_ack),  32'(j == 4));
      chk("t4_host_ack", 32'(host_ack), 32'(j != 4));
    end
    chk("t4_cpu_rdata", 32'(cpu_rdata), 32'hA050);
    step(); host_req = 1'b0; #1;
    chk("t4_end_idle",   32'({cpu_ack, host_ack}), 32'd0);
    chk("t4_host_rdata", 32'(host_rdata), 32'hA040);

    // Reset during a host write grant
    step();
    host_req = 1'b1; host_addr = 16'h0060; host_wdata = 16'hDEAD; host_wren = 1'b1;
    #1;
    chk("t5_c1_host_ack", 32'(host_ack), 32'd0);
    step(); #1;
    chk("t5_c2_host_ack", 32'(host_ack), 32'd1);
    chk("t5_c2_wren",     32'(wren_b),   32'd1);
    chk("t5_c2_addr",     32'(address_b), 32'h0060);
    #1 reset = 1'b0;
    #0.5;
    chk("t5_rst_wren",     32'(wren_b),    32'd0);
    chk("t5_rst_host_ack", 32'(host_ack),  32'd0);
    chk("t5_rst_addr",     32'(address_b), 32'd0);
    host_req = 1'b0; host_wren = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    word = written[8'h60] ? mem[8'h60] : 16'hA060;
    chk("t5_mem_unchanged", 32'(word), 32'hA060);
    chk("t5_host_rdata",    32'(host_rdata), 32'd0);
    chk("t5_cpu_rdata",     32'(cpu_rdata),  32'd0);
    step();
    cpu_req = 1'b1; cpu_addr = 16'h0070; cpu_wren = 1'b0;
    host_req = 1'b1; host_addr = 16'h0071; host_wren = 1'b0;
    #1;
    chk("t5_t1_idle", 32'({cpu_ack, host_ack}), 32'd0);
    step(); #1;
    chk("t5_t2_cpu_ack",  32'(cpu_ack),  32'd1);
    chk("t5_t2_host_ack", 32'(host_ack), 32'd0);
    step(); cpu_req = 1'b0; #1;
    chk("t5_t3_host_ack", 32'(host_ack), 32'd1);
    chk("t5_t3_cpu_ack",  32'(cpu_ack),  32'd0);
    step(); host_req = 1'b0; #1;
    chk("t5_t4_cpu_rdata",  32'(cpu_rdata),  32'hA070);
    chk("t5_t4_host_rdata", 32'(host_rdata), 32'hA071);

    // Host request withdrawn while the CPU is being served
    step(); cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_wren = 1'b0; #1;
    chk("t6_w1_stall", 32'(cpu_stall), 32'd1);
    step(); host_req = 1'b1; host_addr = 16'h0080; host_wren = 1'b0; #1;
    chk("t6_w2_cpu_ack",  32'(cpu_ack),  32'd1);
    chk("t6_w2_host_ack", 32'(host_ack), 32'd0);
    step(); cpu_req = 1'b0; host_req = 1'b0; #1;
    chk("t6_w3_host_ack", 32'(host_ack),  32'd0);
    chk("t6_w3_cpu_ack",  32'(cpu_ack),   32'd0);
    chk("t6_w3_addr",     32'(address_b), 32'd0);
    chk("t6_w3_wren",     32'(wren_b),    32'd0);
    chk("t6_w3_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    step(); #1;
    chk("t6_w4_host_ack", 32'(host_ack), 32'd0);

    compares = compares + proto_checks;
    fails    = fails + proto_fails;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
